// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, feeder state type and ack timer sizing for the uart feeder
package uart_pkg;

  localparam int DEF_DATA_W      = 7;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_ACK_TIMEOUT = 15;

  // Ack timer counts 0..timeout-1, so it needs clog2(timeout) bits (at least one).
  function automatic int ack_tmr_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int DEF_ACK_TMR_W = ack_tmr_width(DEF_ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock character FIFO with occupancy count
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_push_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  // Full/empty come from the registered count only; a push while full is refused
  // even if a pop happens in the same cycle.
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers characters and drains them into the uart data/wr/busy port
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       uart_data,
  output logic                    uart_wr,
  input  logic                    uart_busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    overflow
);

  localparam int TMR_W = ack_tmr_width(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  feeder_state_e r_state;
  feeder_state_e w_state_nxt;

  logic [DATA_W-1:0]      r_data;
  logic [TMR_W-1:0]       r_tmr;
  logic                   r_overflow;

  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [DATA_W-1:0]      w_head;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_tmr_clr;
  logic                   w_tmr_inc;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .res         (res),
    .i_push      (in_valid),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign in_ready  = !w_full;
  assign count     = w_count;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign uart_data = r_data;
  assign uart_wr   = w_wr;

  // Drain state register.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain sequencing: pop only when the uart is idle, pulse wr once, then wait for
  // busy to rise (bounded by the ack timer) and fall before the next character.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_wr        = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !uart_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_wr        = 1'b1;
        w_tmr_clr   = 1'b1;
        w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (uart_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_tmr == TMR_LAST) begin
          // uart never acknowledged; the character is dropped, not retried
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output character register: loaded on pop, held until the next pop.
  always_ff @(posedge clk) begin
    if (res) begin
      r_data <= '0;
    end else if (w_pop) begin
      r_data <= w_head;
    end
  end

  // Ack timer: cleared while issuing, advanced each WAIT_ACK cycle without busy.
  always_ff @(posedge clk) begin
    if (res) begin
      r_tmr <= '0;
    end else if (w_tmr_clr) begin
      r_tmr <= '0;
    end else if (w_tmr_inc) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  // Sticky overflow flag: any write attempt while full is remembered until reset.
  always_ff @(posedge clk) begin
    if (res) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized and directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int DW    = 7;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] uart_data;
  logic          uart_wr;
  logic          uart_busy = 1'b0;
  logic [4:0]    count;
  logic          empty;
  logic          overflow;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(DW), .ACK_TIMEOUT(15)) dut (
    .clk       (clk),
    .res       (res),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uart_data (uart_data),
    .uart_wr   (uart_wr),
    .uart_busy (uart_busy),
    .count     (count),
    .empty     (empty),
    .overflow  (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: queue of characters held, sticky overflow, uart busy model
  logic [DW-1:0] m_q[$];
  bit            m_ovf = 1'b0;
  bit            ack_en = 1'b1;
  bit            b_force = 1'b0;
  bit            b_on = 1'b0;
  int            ack_delay = 1;
  int            busy_len = 100;
  int            b_delay = 0;
  int            b_left = 0;
  bit            hold_chk = 1'b0;
  logic [DW-1:0] last_char = '0;
  bit            prev_wr = 1'b0;
  int            wr_total = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit            pre_valid;
    bit            pre_res;
    bit            pre_busy;
    bit            pre_full;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] exp_c;
    pre_valid = in_valid;
    pre_res   = res;
    pre_busy  = uart_busy;
    pre_data  = in_data;
    pre_full  = (m_q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (pre_res) begin
      m_q.delete();
      m_ovf    = 1'b0;
      hold_chk = 1'b0;
      check_eq("wr_after_res", uart_wr, 0);
      check_eq("data_after_res", uart_data, 0);
    end else begin
      if (uart_wr) begin
        check_eq("wr_busy_low", pre_busy, 0);
        check_eq("wr_single_pulse", prev_wr, 0);
        check_eq("wr_q_nonempty", int'(m_q.size() > 0), 1);
        if (m_q.size() > 0) begin
          exp_c = m_q.pop_front();
          check_eq("wr_data", uart_data, exp_c);
          last_char = exp_c;
        end
        wr_total++;
      end
      if (pre_valid) begin
        if (!pre_full) m_q.push_back(pre_data);
        else m_ovf = 1'b1;
      end
    end
    check_eq("count", count, m_q.size());
    check_eq("empty", empty, int'(m_q.size() == 0));
    check_eq("in_ready", in_ready, int'(m_q.size() < DEPTH));
    check_eq("overflow", overflow, m_ovf);
    if (hold_chk) check_eq("data_hold", uart_data, last_char);
    prev_wr = uart_wr;
    // uart busy behaviour: rises ack_delay cycles after wr, stays high busy_len cycles
    if (b_delay > 0) begin
      b_delay--;
      if (b_delay == 0) begin
        b_on   = 1'b1;
        b_left = busy_len;
      end
    end else if (b_on) begin
      b_left--;
      if (b_left <= 0) begin
        b_on     = 1'b0;
        hold_chk = 1'b0;
      end
    end
    if (uart_wr && !pre_res && ack_en) begin
      b_delay  = ack_delay;
      hold_chk = 1'b1;
    end
    uart_busy = b_force | b_on;
  endtask

  task automatic set_force(input bit f);
    b_force   = f;
    uart_busy = b_force | b_on;
  endtask

  task automatic push(input logic [DW-1:0] c);
    in_data  = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc);
    int n = 0;
    while ((m_q.size() != 0 || uart_busy || b_delay != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("quiet_reached", int'(n < max_cyc), 1);
    repeat (20) tick();
  endtask

  task automatic wait_wr(input string tag, input int max_cyc, output int n);
    n = 0;
    while (!uart_wr && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq(tag, int'(uart_wr), 1);
  endtask

  initial begin
    int n;
    int gap;

    // 1. reset
    res = 1'b1;
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_wr", uart_wr, 0);
    check_eq("rst_overflow", overflow, 0);
    res = 1'b0;
    tick();

    // 2. single character latency and hold
    wr_total  = 0;
    busy_len  = 100;
    ack_delay = 1;
    push(7'h41);
    n = 1;
    while (!uart_wr && n < 20) begin
      tick();
      n++;
    end
    check_eq("single_latency", n, 2);
    check_eq("single_data", uart_data, 'h41);
    wait_quiet(300);
    check_eq("single_wr_total", wr_total, 1);

    // 3. burst of 16 while the uart is held busy, then drain in order
    set_force(1'b1);
    for (int i = 0; i < 16; i++) push(7'(8'h30 + i));
    check_eq("burst_count", count, 16);
    check_eq("burst_in_ready", in_ready, 0);
    check_eq("burst_overflow", overflow, 0);
    busy_len = 3;
    wr_total = 0;
    set_force(1'b0);
    wait_quiet(2000);
    check_eq("burst_wr_total", wr_total, 16);

    // 4. overflow with busy stuck high
    set_force(1'b1);
    for (int i = 0; i < 17; i++) push(7'($urandom));
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_count", count, 16);
    repeat (5) tick();
    check_eq("ovf_sticky", overflow, 1);
    res = 1'b1;
    tick();
    res = 1'b0;
    check_eq("ovf_cleared", overflow, 0);
    set_force(1'b0);
    tick();

    // 5. ack timeout: busy never rises, next character follows 17 cycles later
    ack_en = 1'b0;
    push(7'h55);
    push(7'h56);
    wait_wr("to_first_wr", 20, n);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!uart_wr && gap < 60);
    check_eq("to_gap", gap, 17);
    wait_quiet(100);
    check_eq("to_count", count, 0);
    ack_en   = 1'b1;
    busy_len = 4;
    wr_total = 0;
    push(7'h2A);
    wait_quiet(200);
    check_eq("to_next_issued", wr_total, 1);

    // 6a. simultaneous push and pop at count 3
    set_force(1'b1);
    push(7'h01);
    push(7'h02);
    push(7'h03);
    check_eq("pp_pre_count", count, 3);
    set_force(1'b0);
    push(7'h77);
    check_eq("pp_wr", uart_wr, 1);
    check_eq("pp_count", count, 3);
    wait_quiet(500);

    // 6b. reset during WAIT_DONE
    busy_len = 50;
    push(7'h11);
    wait_wr("wd_wr", 20, n);
    push(7'h12);
    push(7'h13);
    repeat (3) tick();
    check_eq("wd_busy", uart_busy, 1);
    res = 1'b1;
    tick();
    res = 1'b0;
    check_eq("wd_count", count, 0);
    check_eq("wd_empty", empty, 1);
    check_eq("wd_wr", uart_wr, 0);
    wait_quiet(200);

    // 7. randomized traffic with random ack delay, busy length and lost acks
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 40);
      in_data   = 7'($urandom);
      ack_delay = $urandom_range(1, 4);
      busy_len  = $urandom_range(1, 8);
      ack_en    = ($urandom_range(0, 9) != 0);
      tick();
    end
    in_valid = 1'b0;
    ack_en   = 1'b1;
    wait_quiet(3000);
    check_eq("rand_drained", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
